fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined MIPS core, directly upstream of the next-PC logic and the decode stage. Holds the architectural PC, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PC+4 in a small FIFO. Decode drains the FIFO with valid/ready; the next-PC logic redirects the PC on taken branches and jumps, which flushes buffered and in-flight fetches.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the MIPS core front end.
//   word_t          32-bit machine word
//   fetch_state_e   fetch sequencer states (IDLE, WAIT, DISCARD)
//   fetch_entry_t   one fetch buffer entry {instr, pc4}
//   RESET_PC_DEF    default PC after reset
//   word_align()    clears the byte-offset bits of an address
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        word_t instr;
        word_t pc4;
    } fetch_entry_t;

    function automatic word_t word_align(input word_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake bundle between the fetch stage and its neighbours.
//   Instruction memory: imem_req/imem_addr (fetch -> mem), imem_gnt,
//                       imem_rvalid, imem_rdata (mem -> fetch)
//   Decode:             id_valid/id_instr/id_pc4 (fetch -> decode),
//                       id_ready (decode -> fetch)
// master: the fetch unit side; slave: memory + decode side.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    word_t imem_rdata;

    logic  id_valid;
    logic  id_ready;
    word_t id_instr;
    word_t id_pc4;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc4,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc4,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetched {instr, pc4} entries.
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empties the buffer; wins over push_i
//   push_i/data_i  write one entry (caller guarantees space)
//   pop_i          drop the head entry (caller guarantees non-empty)
//   count_o        number of stored entries
//   head_o         oldest entry (contents meaningless when count_o == 0)
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 data_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output fetch_entry_t                 head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [CW-1:0]  count_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   clk, reset     clock, synchronous active-high reset
//   redirect       taken branch/jump from next-PC logic this cycle
//   redirect_pc    branch/jump target (byte offset ignored)
//   bus (master)   instruction memory request/grant/response and
//                  decode valid/ready head {id_instr, id_pc4}
// Keeps at most one memory request outstanding and only issues when the
// buffer has room, so a returning response can always be stored.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter word_t       RESET_PC = RESET_PC_DEF,
    parameter int unsigned DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  word_t           redirect_pc,
    fetch_unit_if.master    bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e   state_q;
    word_t          pc_q;
    word_t          req_pc_q;

    logic [CW-1:0]  count;
    fetch_entry_t   head;
    fetch_entry_t   push_data;
    logic           req;
    logic           grant;
    logic           push;
    logic           pop;

    assign req       = (state_q == IDLE) && (count < CW'(DEPTH));
    assign grant     = req && bus.imem_gnt;
    assign push      = (state_q == WAIT) && bus.imem_rvalid && !redirect;
    assign pop       = (count != '0) && bus.id_ready;
    assign push_data = '{instr: bus.imem_rdata, pc4: req_pc_q + 32'd4};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (redirect),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .count_o (count),
        .head_o  (head)
    );

    // Any response that belongs to a pre-redirect request must be swallowed
    // in DISCARD; a response arriving in the redirect cycle itself settles
    // the debt, so the sequencer can go straight back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else if (redirect) begin
            pc_q <= word_align(redirect_pc);
            unique case (state_q)
                IDLE:    state_q <= grant ? DISCARD : IDLE;
                WAIT:    state_q <= bus.imem_rvalid ? IDLE : DISCARD;
                DISCARD: state_q <= bus.imem_rvalid ? IDLE : DISCARD;
                default: state_q <= IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= WAIT;
                    end
                end
                WAIT, DISCARD: begin
                    if (bus.imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = (count != '0);
    assign bus.id_instr  = head.instr;
    assign bus.id_pc4    = head.pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + short constrained-random stimulus for fetch_unit,
// checked every cycle against a queue-based reference model, plus literal
// expectations at key points of each scenario.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic  clk = 1'b0;
    logic  reset;
    logic  redirect;
    word_t redirect_pc;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: PC, one outstanding-request flag, a "response is
    // stale" flag and a queue of buffered {instr, pc4} words.
    word_t        m_pc;
    word_t        m_reqpc;
    bit           m_out;
    bit           m_stale;
    logic [63:0]  m_q[$];

    function automatic bit m_req();
        return !m_out && (m_q.size() < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit pop_m, grant_m, resp_m;
        if (reset) begin
            m_pc    = 32'h0000_3000;
            m_reqpc = '0;
            m_out   = 1'b0;
            m_stale = 1'b0;
            m_q.delete();
        end else begin
            pop_m   = (m_q.size() != 0) && bus.id_ready;
            grant_m = m_req() && bus.imem_gnt;
            resp_m  = m_out && bus.imem_rvalid;
            if (redirect) begin
                m_q.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                if (!m_out) begin
                    m_out   = grant_m;
                    m_stale = grant_m;
                end else if (resp_m) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end else begin
                if (pop_m) void'(m_q.pop_front());
                if (resp_m) begin
                    if (!m_stale) m_q.push_back({bus.imem_rdata, m_reqpc + 32'd4});
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end
                if (grant_m) begin
                    m_reqpc = m_pc;
                    m_pc    = m_pc + 32'd4;
                    m_out   = 1'b1;
                    m_stale = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] h;
        if (chk_en) begin
            chk("imem_req", bus.imem_req, m_req());
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("id_valid", bus.id_valid, (m_q.size() != 0));
            if (m_q.size() != 0) begin
                h = m_q[0];
                chk("id_instr", bus.id_instr, h[63:32]);
                chk("id_pc4", bus.id_pc4, h[31:0]);
            end
        end
    end

    // One clock: apply inputs, wait for the edge, sample #1 after it.
    task automatic cyc(input bit g, input bit rv, input word_t rd, input bit rdy,
                       input bit rdr, input word_t rpc);
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.id_ready    = rdy;
        redirect        = rdr;
        redirect_pc     = rpc;
        @(posedge clk);
        #1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        redirect        = 1'b0;
    endtask

    task automatic fetch_one(input word_t data, input bit rdy);
        cyc(1'b1, 1'b0, '0, rdy, 1'b0, '0);
        cyc(1'b0, 1'b1, data, rdy, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.id_ready    = 1'b0;

        // Reset state
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        chk("rst_req", bus.imem_req, 1);
        chk("rst_addr", bus.imem_addr, 32'h0000_3000);
        chk("rst_valid", bus.id_valid, 0);
        chk("rst_instr", bus.id_instr, 0);
        chk("rst_pc4", bus.id_pc4, 0);
        reset = 1'b0;

        // Streaming with decode always ready
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        chk("first_next_addr", bus.imem_addr, 32'h0000_3004);
        chk("first_req_low", bus.imem_req, 0);
        chk("first_valid_low", bus.id_valid, 0);
        cyc(1'b0, 1'b1, 32'h11, 1'b1, 1'b0, '0);
        chk("s0_instr", bus.id_instr, 32'h11);
        chk("s0_pc4", bus.id_pc4, 32'h3004);
        fetch_one(32'h22, 1'b1);
        chk("s1_instr", bus.id_instr, 32'h22);
        chk("s1_pc4", bus.id_pc4, 32'h3008);
        fetch_one(32'h33, 1'b1);
        chk("s2_instr", bus.id_instr, 32'h33);
        chk("s2_pc4", bus.id_pc4, 32'h300C);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        chk("s_drained", bus.id_valid, 0);

        // Backpressure: buffer fills, request stops, one pop reopens it
        do_reset();
        fetch_one(32'hA1, 1'b0);
        fetch_one(32'hA2, 1'b0);
        chk("bp_full_req", bus.imem_req, 0);
        chk("bp_head", bus.id_instr, 32'hA1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        chk("bp_req_again", bus.imem_req, 1);
        chk("bp_addr", bus.imem_addr, 32'h3008);
        chk("bp_head2_pc4", bus.id_pc4, 32'h3008);

        // Redirect while a response is owed
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0000_3101);
        chk("rw_req", bus.imem_req, 0);
        chk("rw_flushed", bus.id_valid, 0);
        chk("rw_addr", bus.imem_addr, 32'h3100);
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        chk("rw_dropped", bus.id_valid, 0);
        chk("rw_req_back", bus.imem_req, 1);
        fetch_one(32'h55, 1'b0);
        chk("rw_instr", bus.id_instr, 32'h55);
        chk("rw_pc4", bus.id_pc4, 32'h3104);

        // Redirect coinciding with a granted request
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h0000_4000);
        chk("rg_req", bus.imem_req, 0);
        chk("rg_flushed", bus.id_valid, 0);
        chk("rg_addr", bus.imem_addr, 32'h4000);
        cyc(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, '0);
        chk("rg_dropped", bus.id_valid, 0);

        // Redirect coinciding with a pop from a full buffer
        fetch_one(32'hC1, 1'b0);
        fetch_one(32'hC2, 1'b0);
        #2;
        chk("rp_head_transferred", bus.id_instr, 32'hC1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h0000_5000);
        chk("rp_flushed", bus.id_valid, 0);
        chk("rp_addr", bus.imem_addr, 32'h5000);

        // Redirect in the same cycle the response returns
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b1, 1'b1, 32'h0000_6000);
        chk("rr_req", bus.imem_req, 1);
        chk("rr_valid", bus.id_valid, 0);

        // PC wrap-around
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'h77, 1'b0);
        chk("wrap_pc4", bus.id_pc4, 32'h0000_0000);
        chk("wrap_next", bus.imem_addr, 32'h0000_0000);

        // Reset while a request is outstanding
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        do_reset();
        chk("mid_rst_addr", bus.imem_addr, 32'h3000);
        chk("mid_rst_valid", bus.id_valid, 0);

        // Protocol-legal random traffic, model-checked every cycle
        for (int unsigned i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)),
                m_out && ($urandom_range(0, 2) != 0),
                $urandom,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 11) == 0),
                $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
